// File: rtl/qdec_pkg.sv
// qdec_pkg: shared definitions for the quadrature step decoder.
//   - 2-bit phase constants ({A,B}) in Gray order 00 -> 01 -> 11 -> 10
//   - FSM state type (INIT, TRACK)
//   - direction constants for up_dn
//   - step_dir(prev, curr): classifies one filtered phase change as
//     {valid, illegal, dir}
package qdec_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } qdec_state_e;

  // Packs in the order {valid, illegal, dir}.
  typedef struct packed {
    logic valid;
    logic illegal;
    logic dir;
  } step_t;

  // Position of a phase along the forward Gray cycle.
  function automatic logic [1:0] phase_pos(input logic [1:0] ph);
    logic [1:0] pos;
    case (ph)
      PH_00:   pos = 2'd0;
      PH_01:   pos = 2'd1;
      PH_11:   pos = 2'd2;
      PH_10:   pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

  // The modulo-4 distance along the Gray cycle tells forward (+1),
  // reverse (-1 == 3), no change (0) and a double-bit jump (2).
  function automatic step_t step_dir(input logic [1:0] prev, input logic [1:0] curr);
    step_t      res;
    logic [1:0] delta;
    delta = phase_pos(curr) - phase_pos(prev);
    res.valid   = 1'b0;
    res.illegal = 1'b0;
    res.dir     = DIR_UP;
    case (delta)
      2'd1: begin
        res.valid = 1'b1;
        res.dir   = DIR_UP;
      end
      2'd3: begin
        res.valid = 1'b1;
        res.dir   = DIR_DN;
      end
      2'd2: begin
        res.illegal = 1'b1;
      end
      default: begin
        res.valid = 1'b0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// qdec_filter: 2-flop synchroniser followed by a debounce counter for one
// raw asynchronous input bit. The filtered level flips on the edge at which
// FILT_CYCLES consecutive synchronised samples have differed from it; any
// sample equal to the current level restarts the count.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   raw    asynchronous input bit
//   level  filtered, registered level
module qdec_filter #(
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // Synchronise the raw pin and debounce the synchronised sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CW'(FILT_CYCLES - 1)) begin
        // This is the FILT_CYCLES-th differing sample in a row.
        level_r <= sync2_r;
        cnt_r   <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;

endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: turns raw quadrature encoder pins (A, B, index) into
// up/down counter controls. Each legal Gray step of the filtered phases
// gives a one-cycle cen pulse with direction on up_dn; a filtered index
// rising edge (when idx_load_en=1) gives a one-cycle load_n=0 with data
// holding the captured preset. Double-bit phase jumps set the sticky err.
// Build option: define QDEC_X1_MODE_EN for x1 counting (cen only on
// 10->00 up and 00->10 down); default is x4 (every legal step counts).
// Ports:
//   clk, reset (synchronous, active-low)
//   a_in, b_in, idx_in      raw asynchronous encoder pins
//   idx_load_en             enables index-triggered loads
//   preset_data [WIDTH]     value loaded on index
//   err_clr                 clears err
//   cen, up_dn, load_n, data [WIDTH], err   registered outputs
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int FILT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             idx_in,
  input  logic             idx_load_en,
  input  logic [WIDTH-1:0] preset_data,
  input  logic             err_clr,
  output logic             cen,
  output logic             up_dn,
  output logic             load_n,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  localparam int IW = $clog2(FILT_CYCLES + 2);

  logic             filt_a_s;
  logic             filt_b_s;
  logic             filt_idx_s;
  logic [1:0]       cur_ab_s;
  step_t            step_s;
  logic             idx_rise_s;
  logic             pulse_s;

  qdec_state_e      state_r;
  qdec_state_e      state_s;
  logic [IW-1:0]    init_cnt_r;
  logic [IW-1:0]    init_cnt_s;
  logic [1:0]       ref_r;
  logic [1:0]       ref_s;
  logic             idx_prev_r;
  logic             cen_r;
  logic             cen_s;
  logic             up_dn_r;
  logic             up_dn_s;
  logic             load_n_r;
  logic             load_n_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_s;
  logic             err_r;
  logic             err_s;

  qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk(clk), .reset(reset), .raw(a_in), .level(filt_a_s)
  );
  qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk(clk), .reset(reset), .raw(b_in), .level(filt_b_s)
  );
  qdec_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_idx (
    .clk(clk), .reset(reset), .raw(idx_in), .level(filt_idx_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    cur_ab_s   = {filt_a_s, filt_b_s};
    step_s     = step_dir(ref_r, cur_ab_s);
    idx_rise_s = filt_idx_s & ~idx_prev_r;
    pulse_s    = 1'b0;
    state_s    = state_r;
    init_cnt_s = init_cnt_r;
    ref_s      = ref_r;
    cen_s      = 1'b0;
    up_dn_s    = up_dn_r;
    load_n_s   = 1'b1;
    data_s     = data_r;
    err_s      = err_r & ~err_clr;
    case (state_r)
      INIT: begin
        // Let the filters settle, then take the current phase as reference.
        if (init_cnt_r == IW'(FILT_CYCLES + 1)) begin
          ref_s   = cur_ab_s;
          state_s = TRACK;
        end else begin
          init_cnt_s = init_cnt_r + IW'(1);
        end
      end
      TRACK: begin
        ref_s = cur_ab_s;
`ifdef QDEC_X1_MODE_EN
        pulse_s = step_s.valid &
                  (((ref_r == PH_10) && (cur_ab_s == PH_00)) ||
                   ((ref_r == PH_00) && (cur_ab_s == PH_10)));
`else
        pulse_s = step_s.valid;
`endif
        if (step_s.illegal) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r & ~err_clr;
        end
        // A load takes priority; a coincident step is dropped.
        if (idx_rise_s && idx_load_en) begin
          load_n_s = 1'b0;
          data_s   = preset_data;
        end else if (pulse_s) begin
          cen_s   = 1'b1;
          up_dn_s = step_s.dir;
        end else begin
          cen_s = 1'b0;
        end
      end
      default: begin
        state_s    = INIT;
        init_cnt_s = {IW{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= INIT;
      init_cnt_r <= {IW{1'b0}};
      ref_r      <= PH_00;
      idx_prev_r <= 1'b0;
      cen_r      <= 1'b0;
      up_dn_r    <= DIR_UP;
      load_n_r   <= 1'b1;
      data_r     <= {WIDTH{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      init_cnt_r <= init_cnt_s;
      ref_r      <= ref_s;
      idx_prev_r <= filt_idx_s;
      cen_r      <= cen_s;
      up_dn_r    <= up_dn_s;
      load_n_r   <= load_n_s;
      data_r     <= data_s;
      err_r      <= err_s;
    end
  end

  assign cen    = cen_r;
  assign up_dn  = up_dn_r;
  assign load_n = load_n_r;
  assign data   = data_r;
  assign err    = err_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
`timescale 1ns/1ps
module tb_quad_step_decoder;

  localparam int WIDTH = 4;
  localparam int FILT  = 3;
`ifdef QDEC_X1_MODE_EN
  localparam int FWD_PULSES = 1;
  localparam int FWD_FIRST  = 36;
  localparam int REV_PULSES = 1;
`else
  localparam int FWD_PULSES = 4;
  localparam int FWD_FIRST  = 6;
  localparam int REV_PULSES = 4;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             a_in = 1'b0;
  logic             b_in = 1'b0;
  logic             idx_in = 1'b0;
  logic             idx_load_en = 1'b0;
  logic [WIDTH-1:0] preset_data = 4'h0;
  logic             err_clr = 1'b0;
  logic             cen;
  logic             up_dn;
  logic             load_n;
  logic [WIDTH-1:0] data;
  logic             err;

  always #5 clk = ~clk;

  quad_step_decoder #(.WIDTH(WIDTH), .FILT_CYCLES(FILT)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .idx_load_en(idx_load_en), .preset_data(preset_data), .err_clr(err_clr),
    .cen(cen), .up_dn(up_dn), .load_n(load_n), .data(data), .err(err)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural reference model state
  logic [1:0]       gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  bit               m_valid = 1'b0;
  int               since_rst = 0;
  bit               lvl [3] = '{1'b0, 1'b0, 1'b0};
  bit               lvl_prev [3] = '{1'b0, 1'b0, 1'b0};
  bit               raw_d1 [3] = '{1'b0, 1'b0, 1'b0};
  bit               raw_d2 [3] = '{1'b0, 1'b0, 1'b0};
  bit               rst_d1 = 1'b0;
  bit               rst_d2 = 1'b0;
  bit               win [3][FILT];
  bit               e_cen = 1'b0;
  bit               e_up = 1'b1;
  bit               e_load_n = 1'b1;
  logic [WIDTH-1:0] e_data = 4'h0;
  bit               e_err = 1'b0;

  // Per-segment observation counters
  int               seg_tick, seg_cen, seg_first, seg_up, seg_load, seg_both;
  logic [WIDTH-1:0] seg_ldata;

  function automatic int gidx(input logic [1:0] ph);
    for (int i = 0; i < 4; i++) begin
      if (gray_seq[i] == ph) return i;
    end
    return 0;
  endfunction

  // One clock edge of the reference model; inputs are the values present at the edge.
  task automatic model_step();
    bit         rawv [3];
    logic [1:0] prev_ph, cur_ph;
    int         d;
    bit         step, load, samp, all_diff;
    rawv[0] = a_in; rawv[1] = b_in; rawv[2] = idx_in;
    if (!reset) begin
      e_cen = 1'b0; e_up = 1'b1; e_load_n = 1'b1; e_data = 4'h0; e_err = 1'b0;
      since_rst = 0;
      m_valid = 1'b1;
    end else begin
      since_rst++;
      e_cen = 1'b0;
      e_load_n = 1'b1;
      e_err = e_err && !err_clr;
      if (since_rst >= FILT + 3) begin
        prev_ph = {lvl_prev[0], lvl_prev[1]};
        cur_ph  = {lvl[0], lvl[1]};
        d = (gidx(cur_ph) - gidx(prev_ph) + 4) % 4;
        if (d == 2) e_err = 1'b1;
`ifdef QDEC_X1_MODE_EN
        step = (prev_ph == 2'b10 && cur_ph == 2'b00) || (prev_ph == 2'b00 && cur_ph == 2'b10);
`else
        step = (d == 1) || (d == 3);
`endif
        load = lvl[2] && !lvl_prev[2] && idx_load_en;
        if (load) begin
          e_load_n = 1'b0;
          e_data = preset_data;
        end else if (step) begin
          e_cen = 1'b1;
          e_up = (d == 1);
        end
      end
    end
    // Filtered levels: flip once the last FILT synchronised samples all differ.
    for (int ch = 0; ch < 3; ch++) begin
      samp = (!rst_d1 || !rst_d2) ? 1'b0 : raw_d2[ch];
      for (int j = 0; j < FILT - 1; j++) win[ch][j] = win[ch][j+1];
      win[ch][FILT-1] = samp;
      lvl_prev[ch] = lvl[ch];
      all_diff = 1'b1;
      for (int j = 0; j < FILT; j++) if (win[ch][j] == lvl[ch]) all_diff = 1'b0;
      if (!reset) lvl[ch] = 1'b0;
      else if (all_diff) lvl[ch] = !lvl[ch];
      raw_d2[ch] = raw_d1[ch];
      raw_d1[ch] = rawv[ch];
    end
    rst_d2 = rst_d1;
    rst_d1 = reset;
  endtask

  task automatic seg_clear();
    seg_tick = 0; seg_cen = 0; seg_first = 0; seg_up = 0; seg_load = 0; seg_both = 0;
    seg_ldata = 4'h0;
  endtask

  // Advance n cycles, checking every output against the model after each edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      seg_tick++;
      if (m_valid) begin
        tests++;
        if ({cen, up_dn, load_n, data, err} !== {e_cen, e_up, e_load_n, e_data, e_err}) begin
          fails++;
          $display("FAIL model_cmp t=%0t got cen=%b up_dn=%b load_n=%b data=%h err=%b, expected cen=%b up_dn=%b load_n=%b data=%h err=%b",
                   $time, cen, up_dn, load_n, data, err, e_cen, e_up, e_load_n, e_data, e_err);
        end
      end
      if (cen === 1'b1) begin
        seg_cen++;
        if (seg_first == 0) seg_first = seg_tick;
        if (up_dn === 1'b1) seg_up++;
      end
      if (load_n === 1'b0) begin
        seg_load++;
        seg_ldata = data;
        if (cen !== 1'b0) seg_both++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    a_in = ab[1];
    b_in = ab[0];
  endtask

  int         rpos;
  int         cyc;
  int         r;
  logic [1:0] ph;

  initial begin
    seg_clear();
    for (int ch = 0; ch < 3; ch++) for (int j = 0; j < FILT; j++) win[ch][j] = 1'b0;

    // Reset, then idle at 00
    tick(3);
    reset = 1'b1;
    seg_clear();
    tick(20);
    chk("idle_cen_count", seg_cen, 0);
    chk("idle_err", int'(err), 0);
    chk("idle_load_n", int'(load_n), 1);
    chk("idle_up_dn", int'(up_dn), 1);

    // Forward sequence 00,01,11,10,00
    seg_clear();
    set_ab(2'b01); tick(10);
    set_ab(2'b11); tick(10);
    set_ab(2'b10); tick(10);
    set_ab(2'b00); tick(10);
    chk("fwd_pulses", seg_cen, FWD_PULSES);
    chk("fwd_up_pulses", seg_up, FWD_PULSES);
    chk("fwd_first_latency", seg_first, FWD_FIRST);

    // Reverse sequence 00,10,11,01,00
    seg_clear();
    set_ab(2'b10); tick(10);
    chk("rev_first_latency", seg_first, 6);
    set_ab(2'b11); tick(10);
    set_ab(2'b01); tick(10);
    set_ab(2'b00); tick(10);
    chk("rev_pulses", seg_cen, REV_PULSES);
    chk("rev_up_pulses", seg_up, 0);

    // Short glitch on A is filtered out
    seg_clear();
    a_in = 1'b1; tick(2);
    a_in = 1'b0; tick(10);
    chk("glitch_cen", seg_cen, 0);
    chk("glitch_err", int'(err), 0);

    // Illegal jump 00->11, then clear
    seg_clear();
    set_ab(2'b11); tick(10);
    chk("illegal_cen", seg_cen, 0);
    chk("illegal_err", int'(err), 1);
    err_clr = 1'b1; tick(1);
    err_clr = 1'b0;
    chk("err_cleared", int'(err), 0);
    set_ab(2'b10); tick(10);
    set_ab(2'b00); tick(10);

    // Index load
    idx_load_en = 1'b1; preset_data = 4'hA;
    seg_clear();
    idx_in = 1'b1; tick(5);
    idx_in = 1'b0; tick(10);
    chk("idx_load_count", seg_load, 1);
    chk("idx_load_data", int'(seg_ldata), 10);
    preset_data = 4'h5; tick(5);
    chk("data_holds", int'(data), 10);

    // Index ignored when disabled
    idx_load_en = 1'b0;
    seg_clear();
    idx_in = 1'b1; tick(5);
    idx_in = 1'b0; tick(10);
    chk("idx_disabled_loads", seg_load, 0);

    // Index edge coincident with a forward step: load wins
    idx_load_en = 1'b1; preset_data = 4'h3;
    seg_clear();
    set_ab(2'b01); idx_in = 1'b1; tick(5);
    idx_in = 1'b0; tick(10);
    chk("collide_loads", seg_load, 1);
    chk("collide_cen", seg_cen, 0);
    chk("collide_both", seg_both, 0);

    // Mid-sequence reset after setting err and stepping
    set_ab(2'b10); tick(10);
    set_ab(2'b11); tick(10);
    reset = 1'b0; set_ab(2'b00); tick(1);
    chk("rst_cen", int'(cen), 0);
    chk("rst_up_dn", int'(up_dn), 1);
    chk("rst_load_n", int'(load_n), 1);
    chk("rst_data", int'(data), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b1;
    seg_clear();
    tick(20);
    chk("post_rst_cen", seg_cen, 0);

    // Randomised walk checked against the model every cycle
    rpos = 0;
    cyc = 0;
    while (cyc < 4000) begin
      r = $urandom_range(0, 9);
      if (r == 0) rpos = (rpos + 2) % 4;
      else if (r <= 4) rpos = (rpos + 1) % 4;
      else if (r <= 8) rpos = (rpos + 3) % 4;
      ph = gray_seq[rpos];
      set_ab(ph);
      if ($urandom_range(0, 3) == 0) idx_in = !idx_in;
      idx_load_en = ($urandom_range(0, 3) != 0);
      preset_data = 4'($urandom_range(0, 15));
      err_clr = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      r = $urandom_range(1, 9);
      tick(r);
      cyc += r;
    end
    err_clr = 1'b0;
    reset = 1'b1;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
